// File: rtl/ks_gen_pkg.sv
// Shared types and constants for the keystream generator: FSM states,
// GF(2^8) reduction constant and the byte/word widths.
package ks_gen_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN,
        ST_DONE
    } ks_state_e;

    // Multiplication by 2 in GF(2^8), reduced by GF_POLY.
    function automatic logic [BYTE_W-1:0] xt(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : '0);
    endfunction

endpackage

// File: rtl/ks_gen_s.sv
// Byte-mixing function s: folds the 32-bit state {A0,A1,A2,A3} into one byte
// f = A0 ^ xt(A1^A2) ^ A2 ^ A3. Purely combinational.
module s
    import ks_gen_pkg::*;
(
    input  logic [WORD_W-1:0] data_in,
    output logic [BYTE_W-1:0] data_out
);

    logic [BYTE_W-1:0] a0, a1, a2, a3;

    assign a0 = data_in[31:24];
    assign a1 = data_in[23:16];
    assign a2 = data_in[15:8];
    assign a3 = data_in[7:0];

    assign data_out = a0 ^ xt(a1 ^ a2) ^ a2 ^ a3;

endmodule

// File: rtl/ks_gen.sv
// Keystream generator: a 32-bit shift-and-mix state that is seeded, stepped
// WARMUP times without output, then emits len bytes under valid/ready.
module ks_gen
    import ks_gen_pkg::*;
#(
    parameter int WARMUP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed_in,
    input  logic        start,
    input  logic [15:0] len,
    output logic [7:0]  ks_out,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    ks_state_e         state_q, state_nxt;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_step;
    logic [15:0]       rem_q;
    logic [7:0]        warm_q;
    logic              done_q;
    logic [BYTE_W-1:0] f;
    logic              xfer;

    s u_mix (
        .data_in  (word_q),
        .data_out (f)
    );

    assign word_step = {word_q[23:0], f};
    assign xfer      = ks_valid & ks_ready;

    assign ks_out   = f;
    assign ks_valid = (state_q == ST_RUN) && (rem_q != '0);
    assign busy     = (state_q == ST_WARMUP) || (state_q == ST_RUN);
    assign done     = done_q;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
                end
            end
            ST_WARMUP: begin
                if (warm_q == WARM_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Leave on the last transfer, or at once when the run was empty.
                if (rem_q == '0 || (xfer && rem_q == 16'd1)) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            rem_q   <= '0;
            warm_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            done_q  <= (state_nxt == ST_DONE) && (state_q != ST_DONE);
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        word_q <= seed_in;
                    end
                    if (start) begin
                        rem_q  <= len;
                        warm_q <= '0;
                    end
                end
                ST_WARMUP: begin
                    word_q <= word_step;
                    warm_q <= warm_q + 8'd1;
                end
                ST_RUN: begin
                    if (xfer) begin
                        word_q <= word_step;
                        rem_q  <= rem_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ks_gen.sv
// Bench for ks_gen: two instances (WARMUP 0 and 4) on shared stimulus, each
// compared every cycle against a byte-level reference model.
module tb_ks_gen;

    logic        clk = 1'b0;
    logic        rst, load, start, ks_ready;
    logic [31:0] seed_in;
    logic [15:0] len;
    logic [7:0]  ks_out0, ks_out4;
    logic        v0, v4, b0, b4, d0, d4;

    always #5 clk = ~clk;

    ks_gen #(.WARMUP(0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .start(start),
        .len(len), .ks_out(ks_out0), .ks_valid(v0), .ks_ready(ks_ready),
        .busy(b0), .done(d0)
    );

    ks_gen #(.WARMUP(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .start(start),
        .len(len), .ks_out(ks_out4), .ks_valid(v4), .ks_ready(ks_ready),
        .busy(b4), .done(d4)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte arithmetic and run bookkeeping.
    function automatic int warm_of(input int j);
        return (j == 0) ? 0 : 4;
    endfunction

    function automatic logic [7:0] m_mix(input logic [31:0] w);
        int a0, a1, a2, a3, t;
        a0 = int'(w[31:24]);
        a1 = int'(w[23:16]);
        a2 = int'(w[15:8]);
        a3 = int'(w[7:0]);
        t  = a1 ^ a2;
        t  = ((t * 2) % 256) ^ ((t >= 128) ? 27 : 0);
        return 8'(a0 ^ t ^ a2 ^ a3);
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] w);
        return {w[23:0], m_mix(w)};
    endfunction

    logic [31:0] m_st[2];
    int          m_warm[2];
    int          m_rem[2];
    bit          m_active[2];
    bit          m_done[2];

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                m_st[j]     <= '0;
                m_warm[j]   <= 0;
                m_rem[j]    <= 0;
                m_active[j] <= 1'b0;
                m_done[j]   <= 1'b0;
            end else begin
                m_done[j] <= 1'b0;
                if (!m_active[j]) begin
                    if (load) m_st[j] <= seed_in;
                    if (start) begin
                        m_active[j] <= 1'b1;
                        m_warm[j]   <= warm_of(j);
                        m_rem[j]    <= int'(len);
                    end
                end else if (m_warm[j] > 0) begin
                    m_st[j]   <= m_step(m_st[j]);
                    m_warm[j] <= m_warm[j] - 1;
                end else if (m_rem[j] == 0) begin
                    m_active[j] <= 1'b0;
                    m_done[j]   <= 1'b1;
                end else if (ks_ready) begin
                    m_st[j]  <= m_step(m_st[j]);
                    m_rem[j] <= m_rem[j] - 1;
                    if (m_rem[j] == 1) begin
                        m_active[j] <= 1'b0;
                        m_done[j]   <= 1'b1;
                    end
                end
            end
        end
    end

    logic [7:0] cap0[$], cap4[$];
    int         done0, done4, warm4;

    always @(negedge clk) begin
        if (checking) begin
            for (int j = 0; j < 2; j++) begin
                logic [7:0] o;
                logic       v, b, d, ev;
                o  = (j == 0) ? ks_out0 : ks_out4;
                v  = (j == 0) ? v0 : v4;
                b  = (j == 0) ? b0 : b4;
                d  = (j == 0) ? d0 : d4;
                ev = m_active[j] && (m_warm[j] == 0) && (m_rem[j] > 0);
                check($sformatf("ks_out_w%0d", warm_of(j)), 32'(o), 32'(m_mix(m_st[j])));
                check($sformatf("ks_valid_w%0d", warm_of(j)), 32'(v), 32'(ev));
                check($sformatf("busy_w%0d", warm_of(j)), 32'(b), 32'(m_active[j]));
                check($sformatf("done_w%0d", warm_of(j)), 32'(d), 32'(m_done[j]));
            end
            if (!rst && v0 && ks_ready) cap0.push_back(ks_out0);
            if (!rst && v4 && ks_ready) cap4.push_back(ks_out4);
            if (d0) done0++;
            if (d4) done4++;
            if (b4 && !v4) warm4++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap0.delete();
        cap4.delete();
        done0 = 0;
        done4 = 0;
        warm4 = 0;
    endtask

    task automatic check_seq(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            check($sformatf("%s_byte%0d", name, k), 32'(got[k]), 32'(exp[k]));
        end
    endtask

    // mode: 0 ready held high, 1 ready pattern 1,0,0,..., 2 random ready.
    // inject_at: loop cycle for a mid-run reset (rst_inj) or a load+start.
    task automatic run(input bit do_load, input logic [31:0] seed, input int n,
                       input int mode, input int inject_at, input bit rst_inj);
        int i;
        clear_caps();
        load    = do_load;
        seed_in = seed;
        start   = 1'b1;
        len     = 16'(n);
        cyc();
        load  = 1'b0;
        start = 1'b0;
        for (i = 0; i < 400; i++) begin
            ks_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 3 == 0) : 1'($urandom_range(0, 1));
            if (i == inject_at) begin
                if (rst_inj) begin
                    rst = 1'b1;
                end else begin
                    load    = 1'b1;
                    start   = 1'b1;
                    seed_in = $urandom;
                    len     = 16'($urandom_range(1, 20));
                end
            end
            cyc();
            rst   = 1'b0;
            load  = 1'b0;
            start = 1'b0;
            if (!b0 && !b4) break;
        end
        check("run_timeout", 32'(i < 400), 32'd1);
        ks_ready = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        logic [7:0] exp_a[$];
        logic [7:0] exp_z[$];
        logic [7:0] exp_e[$];
        exp_a = {8'h01, 8'h01, 8'h02, 8'h03, 8'h06};
        exp_z = {8'h00, 8'h00, 8'h00};
        exp_e = {};

        rst = 1'b1; load = 1'b0; start = 1'b0; ks_ready = 1'b0;
        seed_in = '0; len = '0;
        cyc();
        checking = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_ks_out", 32'(ks_out0), 32'h0);
        check("rst_valid", 32'(v0), 32'h0);
        check("rst_busy", 32'(b4), 32'h0);
        check("rst_done", 32'(d0), 32'h0);
        cyc();

        // Basic sequence with ready held high.
        run(1'b1, 32'h0100_0000, 5, 0, -1, 1'b0);
        check_seq("seq_ready", cap0, exp_a);
        check("seq_ready_done", 32'(done0), 32'd1);

        // Stalling consumer must not lose or duplicate bytes.
        run(1'b1, 32'h0100_0000, 5, 1, -1, 1'b0);
        check_seq("seq_stall", cap0, exp_a);
        check("seq_stall_done", 32'(done0), 32'd1);

        // Four warm-up steps then a single byte.
        run(1'b1, 32'h0100_0000, 1, 0, -1, 1'b0);
        check("warm4_cycles", 32'(warm4), 32'd4);
        check("warm4_byte_count", 32'(cap4.size()), 32'd1);
        if (cap4.size() > 0) check("warm4_byte", 32'(cap4[0]), 32'h06);
        check("warm4_done", 32'(done4), 32'd1);

        // Zero seed, then an empty run that still signals done.
        run(1'b1, 32'h0000_0000, 3, 0, -1, 1'b0);
        check_seq("seq_zero", cap0, exp_z);
        run(1'b0, 32'h0, 0, 0, -1, 1'b0);
        check_seq("len0", cap0, exp_e);
        check("len0_done_w0", 32'(done0), 32'd1);
        check("len0_done_w4", 32'(done4), 32'd1);

        // Load and start during a run are ignored.
        run(1'b1, 32'h0100_0000, 5, 0, 1, 1'b0);
        check_seq("seq_ignore", cap0, exp_a);

        // Reset after the second byte aborts without a done pulse.
        clear_caps();
        load = 1'b1; seed_in = 32'h0100_0000; start = 1'b1; len = 16'd5;
        cyc();
        load = 1'b0; start = 1'b0; ks_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ks_ready = 1'b0;
        check("abort_ks_out", 32'(ks_out0), 32'h0);
        check("abort_valid", 32'(v0), 32'h0);
        check("abort_busy", 32'(b0), 32'h0);
        check("abort_busy_w4", 32'(b4), 32'h0);
        check("abort_bytes", 32'(cap0.size()), 32'd2);
        cyc();
        cyc();
        check("abort_no_done", 32'(done0 + done4), 32'd0);
        run(1'b1, 32'h0100_0000, 5, 0, -1, 1'b0);
        check_seq("seq_after_rst", cap0, exp_a);

        // Randomised runs checked cycle by cycle against the model.
        for (int r = 0; r < 25; r++) begin
            int  sel, at;
            bit  rinj;
            sel  = $urandom_range(0, 4);
            at   = (sel < 2) ? $urandom_range(0, 8) : -1;
            rinj = (sel == 0);
            run(1'($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 10), 2, at, rinj);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ks_gen.md
KS_GEN -- requirements
Module: ks_gen

Interface
REQ-001 Parameter WARMUP, default 16, meaning: number of discarded steps after start; legal range 0..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load  input  1  one-cycle request to load seed_in into the state register.
REQ-005 seed_in  input  32  seed word; byte A0 = [31:24], A1 = [23:16], A2 = [15:8], A3 = [7:0].
REQ-006 start  input  1  one-cycle request to begin a run.
REQ-007 len  input  16  number of keystream bytes for this run; sampled with start.
REQ-008 ks_out  output  8  keystream byte.
REQ-009 ks_valid  output  1  ks_out is valid.
REQ-010 ks_ready  input  1  consumer accepts ks_out.
REQ-011 busy  output  1  high in WARMUP and RUN.
REQ-012 done  output  1  one-cycle pulse at the end of a run.

Function
REQ-013 The state is a 32-bit register {A0,A1,A2,A3}, and f = mix(state) = A0 ^ xt(A1^A2) ^ A2 ^ A3.
- xt is multiplication by 2 in GF(2^8) with reduction 0x1B.
REQ-014 One step replaces the state with {A1,A2,A3,f}.
REQ-015 ks_out is f of the current state register, with no combinational path from inputs.
REQ-016 The FSM has four states: IDLE, WARMUP, RUN and DONE.
REQ-017 In IDLE or DONE, load writes seed_in to the state; load is ignored in WARMUP and RUN.
REQ-018 Start in IDLE or DONE samples len into a 16-bit remaining counter and clears a warm-up counter.
- Next state is WARMUP if WARMUP > 0, else RUN.
- Start is ignored in WARMUP and RUN.
REQ-019 If load and start are asserted in the same cycle, the state takes seed_in and the run begins from that seed.
REQ-020 WARMUP steps once per cycle, ignoring ks_ready, with ks_valid = 0; it enters RUN after exactly WARMUP steps.
REQ-021 RUN: ks_valid = 1 while remaining != 0.
- A transfer (ks_valid & ks_ready) steps the state and decrements remaining.
- With no transfer, the state, remaining and ks_out hold stable.
REQ-022 When remaining reaches 0, or on entry to RUN with len = 0, the FSM enters DONE.
- done pulses for exactly the first cycle in DONE.
- ks_valid = 0 in DONE.
REQ-023 With len = 0 no byte is transferred and done still pulses.
REQ-024 busy = 1 exactly in WARMUP and RUN.
REQ-025 The remaining counter never wraps below 0.

Reset
REQ-026 rst has priority over all other inputs.
REQ-027 Reset values: FSM = IDLE, state = 0x00000000, remaining = 0, warm-up counter = 0.
REQ-028 Outputs after reset: ks_valid = 0, busy = 0, done = 0, ks_out = 0x00.
REQ-029 Reset in mid-run aborts the run on the next edge, with no done pulse.

Structure
REQ-030 A shared package holds the FSM state enum, the GF reduction constant 0x1B and the byte/word width constants.
REQ-031 f is computed by one instantiation of the existing byte-mixing module s.
- data_in = state, data_out = f.
- No duplicate mixing logic is written inline.
REQ-032 All sequential logic lives in a single clocked process using synchronous reset.

Verification
REQ-033 WARMUP = 0, seed 0x01000000, len = 5, ks_ready held 1 -> ks_out sequence 0x01, 0x01, 0x02, 0x03, 0x06 on consecutive cycles, then one done pulse.
REQ-034 WARMUP = 0, same seed, ks_ready toggled 1,0,0,1,... -> the same five bytes, ks_out stable while stalled, no byte lost or duplicated.
REQ-035 WARMUP = 4, seed 0x01000000, len = 1 -> four cycles with busy = 1 and ks_valid = 0, then single byte 0x06, then done.
REQ-036 Seed 0x00000000, len = 3 -> three bytes 0x00; then len = 0 -> no ks_valid, done pulse one cycle after the WARMUP phase.
REQ-037 Load and start asserted during RUN -> ignored, with the sequence unchanged.
REQ-038 rst asserted after the second byte -> next cycle all outputs at reset values and no done pulse; a new load and start with the same seed reproduces 0x01, 0x01, ...
